// File: rtl/rom_stream_reader.sv
// rom_stream_reader: issues credit-limited ROM read bursts and streams the words out through a small FIFO
// Ports: clk/rst (async, active-high); start/base_addr/count request a burst in IDLE;
// rom_cs/rom_addr/rom_data drive and return the registered ROM; out_data/out_valid/out_ready/out_last
// form the output stream; busy covers RUN and DRAIN; done pulses one cycle when the burst completes.
module rom_stream_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_ptr, src_addr;
  logic [ADDR_W:0] remaining, src_rem;
  logic rom_last, cap_valid, cap_last;
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] occ;
  logic [CW-1:0] outstanding;
  logic launch, issue, push, pop, head_last, fin;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE && launch) ? RUN :
               (state == RUN && rom_cs && rom_last) ? DRAIN :
               (state == DRAIN && fin) ? IDLE : state;
  end
  // The issue decision is registered into rom_cs, so credits count the read
  // currently on the bus (rom_cs) and the word being captured (cap_valid).
  always_comb begin
    launch = start && count != '0;
    outstanding = CW'(occ) + CW'(rom_cs) + CW'(cap_valid);
    issue = (state == IDLE) ? launch :
            (state == RUN && remaining != '0 && outstanding < CW'(FIFO_DEPTH));
    src_addr = (state == IDLE) ? base_addr : addr_ptr;
    src_rem = (state == IDLE) ? count : remaining;
    busy = state != IDLE;
    out_valid = occ != '0;
    pop = out_valid && out_ready;
    push = cap_valid;
    head_last = mem[rptr][DATA_W];
    out_data = out_valid ? mem[rptr][DATA_W-1:0] : '0;
    out_last = out_valid && head_last;
    fin = state == DRAIN && pop && head_last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rom_cs <= 1'b0;
      rom_addr <= '0;
      rom_last <= 1'b0;
      addr_ptr <= '0;
      remaining <= '0;
      cap_valid <= 1'b0;
      cap_last <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
      done <= 1'b0;
    end else begin
      rom_cs <= issue;
      if (issue) begin
        rom_addr <= src_addr;
        addr_ptr <= src_addr + ADDR_W'(1);
        remaining <= src_rem - (ADDR_W+1)'(1);
        rom_last <= src_rem == (ADDR_W+1)'(1);
      end
      cap_valid <= rom_cs;
      cap_last <= rom_cs && rom_last;
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      done <= fin || (state == IDLE && start && count == '0);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {cap_last, rom_data};
endmodule
